// File: rtl/mc_pkg.sv
// Shared constants for the Wishbone multi-counter: register offsets, CTRL bit
// positions, channel limits and the byte-lane merge helper.
package mc_pkg;

  localparam int MAX_CHANNELS = 8;
  localparam int WINDOW_BYTES = 256;
  localparam int CHAN_STRIDE  = 16;

  // Register index within a channel, taken from address bits [3:2].
  typedef enum logic [1:0] {
    REG_CTRL   = 2'd0,
    REG_VALUE  = 2'd1,
    REG_RELOAD = 2'd2,
    REG_STATUS = 2'd3
  } reg_off_e;

  localparam logic [7:0] OFF_CTRL   = 8'h0;
  localparam logic [7:0] OFF_VALUE  = 8'h4;
  localparam logic [7:0] OFF_RELOAD = 8'h8;
  localparam logic [7:0] OFF_STATUS = 8'hC;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_DOWN    = 1;
  localparam int CTRL_ONESHOT = 2;
  localparam int CTRL_IRQ_EN  = 3;
  localparam int CTRL_BITS    = 4;

  localparam int STATUS_EXPIRED = 0;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  sel);
    logic [31:0] merged;
    merged = old_word;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) merged[8*b +: 8] = new_word[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/mc_channel.sv
// One counter channel: CTRL/VALUE/RELOAD/STATUS registers, up/down counting,
// periodic or one-shot expiry and a registered level interrupt.
module mc_channel
  import mc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  reg_off_e         wr_off,
  input  logic [31:0]      wr_data,
  input  logic [3:0]       wr_sel,
  input  reg_off_e         rd_off,
  output logic [31:0]      rd_data,
  input  logic             la_force,
  input  logic [WIDTH-1:0] la_value,
  output logic [WIDTH-1:0] value,
  output logic             irq
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [CTRL_BITS-1:0] ctrl_q, ctrl_d;
  logic [WIDTH-1:0]     value_q, value_d;
  logic [WIDTH-1:0]     reload_q, reload_d;
  logic                 status_q, status_d;
  logic                 irq_q;

  logic [31:0] value_ext, reload_ext;
  logic [31:0] value_wr_word, reload_wr_word;
  logic        value_wr, status_clr;
  logic        at_limit, count_en, expire;

  always_comb begin
    value_ext  = '0;
    reload_ext = '0;
    value_ext[WIDTH-1:0]  = value_q;
    reload_ext[WIDTH-1:0] = reload_q;
  end

  assign value_wr_word  = merge_bytes(value_ext, wr_data, wr_sel);
  assign reload_wr_word = merge_bytes(reload_ext, wr_data, wr_sel);

  assign value_wr   = wr_en && (wr_off == REG_VALUE);
  assign status_clr = wr_en && (wr_off == REG_STATUS) && wr_sel[0] && wr_data[STATUS_EXPIRED];

  // A VALUE write or LA override replaces this cycle's count step entirely.
  assign at_limit = ctrl_q[CTRL_DOWN] ? (value_q == '0) : (value_q == reload_q);
  assign count_en = ctrl_q[CTRL_EN] && !value_wr && !la_force;
  assign expire   = count_en && at_limit;

  always_comb begin
    ctrl_d   = ctrl_q;
    value_d  = value_q;
    reload_d = reload_q;

    if (count_en) begin
      if (at_limit) begin
        if (ctrl_q[CTRL_ONESHOT]) begin
          ctrl_d[CTRL_EN] = 1'b0;
        end else if (ctrl_q[CTRL_DOWN]) begin
          value_d = reload_q;
        end else begin
          value_d = '0;
        end
      end else if (ctrl_q[CTRL_DOWN]) begin
        value_d = value_q - ONE;
      end else begin
        value_d = value_q + ONE;
      end
    end

    if (wr_en) begin
      case (wr_off)
        REG_CTRL:   if (wr_sel[0]) ctrl_d = wr_data[CTRL_BITS-1:0];
        REG_VALUE:  value_d  = value_wr_word[WIDTH-1:0];
        REG_RELOAD: reload_d = reload_wr_word[WIDTH-1:0];
        default:    ;
      endcase
    end

    if (la_force) value_d = la_value;
  end

  // Set beats clear when software acks in the same cycle as an expiry.
  assign status_d = expire | (status_q & ~status_clr);

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q   <= '0;
      value_q  <= '0;
      reload_q <= '0;
      status_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_d;
      value_q  <= value_d;
      reload_q <= reload_d;
      status_q <= status_d;
      irq_q    <= status_d & ctrl_d[CTRL_IRQ_EN];
    end
  end

  always_comb begin
    rd_data = '0;
    case (rd_off)
      REG_CTRL:   rd_data[CTRL_BITS-1:0] = ctrl_q;
      REG_VALUE:  rd_data = value_ext;
      REG_RELOAD: rd_data = reload_ext;
      REG_STATUS: rd_data[STATUS_EXPIRED] = status_q;
      default:    rd_data = '0;
    endcase
  end

  assign value = value_q;
  assign irq   = irq_q;

endmodule

// File: rtl/wb_multi_counter.sv
// Wishbone classic slave exposing CHANNELS independent counters in a 256-byte
// window. Optional MULTI_COUNTER_LA_EN lets the logic analyzer force/observe ch0.
module wb_multi_counter
  import mc_pkg::*;
#(
  parameter int          WIDTH     = 32,
  parameter int          CHANNELS  = 3,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                wbs_cyc_i,
  input  logic                wbs_stb_i,
  input  logic                wbs_we_i,
  input  logic [3:0]          wbs_sel_i,
  input  logic [31:0]         wbs_adr_i,
  input  logic [31:0]         wbs_dat_i,
  output logic                wbs_ack_o,
  output logic [31:0]         wbs_dat_o,
  input  logic [127:0]        la_data_in,
  input  logic [127:0]        la_oenb,
  output logic [127:0]        la_data_out,
  output logic [CHANNELS-1:0] irq
);

  logic        in_window, hit, ch_valid;
  logic [3:0]  ch_idx;
  reg_off_e    reg_off;
  logic [31:0] rd_word;

  logic [31:0]                    ch_rd [CHANNELS];
  logic [CHANNELS-1:0][WIDTH-1:0] ch_value;
  logic [CHANNELS-1:0]            ch_irq;

  logic             la_force;
  logic [WIDTH-1:0] la_value;

  assign in_window = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  // Blocking on ack gives the one-cycle ack pulse and the every-other-cycle rate.
  assign hit       = wbs_cyc_i && wbs_stb_i && in_window && !wbs_ack_o;
  assign ch_idx    = wbs_adr_i[7:4];
  assign ch_valid  = int'(ch_idx) < CHANNELS;
  assign reg_off   = reg_off_e'(wbs_adr_i[3:2]);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    logic wr_en_c;
    assign wr_en_c = hit && wbs_we_i && ch_valid && (int'(ch_idx) == c);

    mc_channel #(
      .WIDTH(WIDTH)
    ) u_chan (
      .clk      (wb_clk_i),
      .rst      (wb_rst_i),
      .wr_en    (wr_en_c),
      .wr_off   (reg_off),
      .wr_data  (wbs_dat_i),
      .wr_sel   (wbs_sel_i),
      .rd_off   (reg_off),
      .rd_data  (ch_rd[c]),
      .la_force ((c == 0) ? la_force : 1'b0),
      .la_value (la_value),
      .value    (ch_value[c]),
      .irq      (ch_irq[c])
    );
  end

  always_comb begin
    rd_word = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (ch_valid && (int'(ch_idx) == c)) rd_word = ch_rd[c];
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= hit;
      wbs_dat_o <= (hit && !wbs_we_i) ? rd_word : '0;
    end
  end

  assign irq = ch_irq;

`ifdef MULTI_COUNTER_LA_EN
  assign la_force = !la_oenb[127];
  assign la_value = la_data_in[WIDTH-1:0];

  always_comb begin
    la_data_out = '0;
    la_data_out[WIDTH-1:0] = ch_value[0];
  end
`else
  assign la_force    = 1'b0;
  assign la_value    = '0;
  assign la_data_out = '0;
`endif

  logic unused_ok;
  assign unused_ok = &{1'b0, wbs_adr_i[1:0], ch_value, la_data_in, la_oenb};

endmodule
